// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared FSM encoding and Wishbone widths for wb_master_seq  (rev 1.0)
// ============================================================================
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_master_seq.sv
`default_nettype none
// ============================================================================
// wb_master_seq : single-transfer Wishbone B3 initiator with ack timeout (rev 1.0)
// ============================================================================
module wb_master_seq
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int            TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  wb_state_t       state;
  wb_state_t       next_state;
  logic [TO_W-1:0] to_cnt;
  logic            to_last;

  assign to_last = (to_cnt == TO_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) next_state = BUS;
      end
      // ack takes priority over the timeout limit in the same cycle
      BUS:     if (wbm_ack_i || to_last) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      to_cnt    <= '0;
      txn_count <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            to_cnt    <= '0;
          end
        end
        BUS: begin
          if (!to_last) to_cnt <= to_cnt + TO_W'(1);
          if (wbm_ack_i || to_last) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= !wbm_ack_i;
            rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            txn_count <= txn_count + CNT_W'(1);
            if (!wbm_ack_i && (err_count != '1))
              err_count <= err_count + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_seq.sv
`default_nettype none
// ============================================================================
// tb_wb_master_seq : randomized self-checking bench with a transfer-level model
// ============================================================================
module tb_wb_master_seq;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr, cmd_dat;
  logic [3:0]       cmd_sel;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [31:0]      rsp_dat;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic             busy;
  logic [CNT_W-1:0] txn_count, err_count;

  wb_master_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy     (busy),      .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // transfer-level reference counters
  int m_txn = 0;
  int m_err = 0;

  typedef struct {
    int               acc_cyc;
    logic             ready_at_issue;
    int               stb;
    logic             attr_ok;
    logic             we;
    logic [31:0]      adr, dat;
    logic [3:0]       sel;
    logic             v_at_end;
    logic [31:0]      rdat;
    logic             rerr;
    logic [CNT_W-1:0] txn, errc;
    logic             hold_ok;
    logic             post_ready, post_valid, post_busy;
  } obs_t;

  // An ack in stb cycle 1..TIMEOUT completes the transfer, otherwise it aborts
  // after TIMEOUT stb cycles. Writes and aborts return zero data.
  function automatic void model(input logic we, input int ack_at, input logic [31:0] rdata,
                                output int e_stb, output logic e_err, output logic [31:0] e_dat);
    e_err = !(ack_at >= 1 && ack_at <= TIMEOUT);
    e_stb = e_err ? TIMEOUT : ack_at;
    e_dat = (e_err || we) ? 32'h0 : rdata;
    m_txn = (m_txn + 1) % (1 << CNT_W);
    if (e_err && m_err < (1 << CNT_W) - 1) m_err = m_err + 1;
  endfunction

  // Entered #1 after a rising edge with the DUT idle; leaves it the same way.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                         input int hold, output obs_t o);
    o = '{default: '0};
    o.attr_ok = 1'b1;
    o.hold_ok = 1'b1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    o.ready_at_issue = cmd_ready;
    @(posedge clk); #1;
    o.acc_cyc = cyc_n;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (!wbm_stb_o) break;
      o.stb++;
      if (o.stb == 1) begin
        o.we = wbm_we_o; o.adr = wbm_adr_o; o.dat = wbm_dat_o; o.sel = wbm_sel_o;
      end else if ({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {o.we, o.adr, o.dat, o.sel}) begin
        o.attr_ok = 1'b0;
      end
      if (!wbm_cyc_o || cmd_ready || rsp_valid) o.attr_ok = 1'b0;
      wbm_ack_i = (o.stb == ack_at);
      wbm_dat_i = wbm_ack_i ? rdata : $urandom;
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
    end
    o.v_at_end = rsp_valid; o.rdat = rsp_dat; o.rerr = rsp_err;
    o.txn = txn_count; o.errc = err_count;
    // backpressure: offer a junk command and stray acks while the response waits
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; wbm_ack_i = 1'($urandom); wbm_dat_i = $urandom;
      @(posedge clk); #1;
      if (!rsp_valid || rsp_dat !== o.rdat || rsp_err !== o.rerr || cmd_ready || wbm_cyc_o ||
          txn_count !== o.txn || err_count !== o.errc)
        o.hold_ok = 1'b0;
    end
    cmd_valid = 1'b0; wbm_ack_i = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    o.post_ready = cmd_ready; o.post_valid = rsp_valid; o.post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat,
         rsp_err, busy, txn_count, err_count} !== '0)
      $display("FAIL reset_outputs got cyc=%b stb=%b adr=%h rv=%b busy=%b txn=%0d err=%0d want all zero",
               wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid, busy, txn_count, err_count);
    else n_pass++;
    n_chk++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
    else n_pass++;
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 wbm_ack_i = 1'b0;
    n_chk++;
    if ({rsp_valid, rsp_dat, busy, txn_count, err_count, wbm_cyc_o} !== '0)
      $display("FAIL idle_ack_ignored got rv=%b dat=%h busy=%b txn=%0d err=%0d want zeros",
               rsp_valid, rsp_dat, busy, txn_count, err_count);
    else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    model(1'b1, 1, 32'h0, e_stb, e_err, e_dat);
    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'hCAFE_F00D, 0, o);
    n_chk++;
    if (o.ready_at_issue !== 1'b1) $display("FAIL wr_ready got %b want 1", o.ready_at_issue);
    else n_pass++;
    n_chk++;
    if ({o.we, o.adr, o.dat, o.sel, o.attr_ok} !== {1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1})
      $display("FAIL wr_bus got we=%b adr=%h dat=%h sel=%h ok=%b want 1 30000004 deadbeef f 1",
               o.we, o.adr, o.dat, o.sel, o.attr_ok);
    else n_pass++;
    n_chk++;
    if ({o.stb, o.v_at_end, o.rerr, o.rdat, o.txn, o.errc} !==
        {e_stb, 1'b1, e_err, e_dat, CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL wr_result got stb=%0d rv=%b err=%b dat=%h txn=%0d errc=%0d want stb=%0d rv=1 err=%b dat=%h txn=%0d errc=%0d",
               o.stb, o.v_at_end, o.rerr, o.rdat, o.txn, o.errc, e_stb, e_err, e_dat, m_txn, m_err);
    else n_pass++;
    n_chk++;
    if ({o.post_ready, o.post_valid, wbm_we_o, wbm_adr_o} !== {1'b1, 1'b0, 1'b1, 32'h3000_0004})
      $display("FAIL wr_after got ready=%b rv=%b we=%b adr=%h want 1 0 1 30000004",
               o.post_ready, o.post_valid, wbm_we_o, wbm_adr_o);
    else n_pass++;
  endtask

  task automatic test_read_wait3();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    model(1'b0, 4, 32'h1234_5678, e_stb, e_err, e_dat);
    run_txn(1'b0, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 4, 32'h1234_5678, 0, o);
    n_chk++;
    if ({o.stb, o.attr_ok, o.we, o.adr, o.sel} !== {e_stb, 1'b1, 1'b0, 32'h3000_0010, 4'h3})
      $display("FAIL rd_bus got stb=%0d ok=%b we=%b adr=%h sel=%h want stb=%0d ok=1 we=0 adr=30000010 sel=3",
               o.stb, o.attr_ok, o.we, o.adr, o.sel, e_stb);
    else n_pass++;
    n_chk++;
    if ({o.v_at_end, o.rerr, o.rdat, o.txn, o.errc} !== {1'b1, e_err, e_dat, CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL rd_result got rv=%b err=%b dat=%h txn=%0d errc=%0d want rv=1 err=%b dat=%h txn=%0d errc=%0d",
               o.v_at_end, o.rerr, o.rdat, o.txn, o.errc, e_err, e_dat, m_txn, m_err);
    else n_pass++;
    n_chk++;
    if (o.post_ready !== 1'b1) $display("FAIL rd_ready_after got %b want 1", o.post_ready);
    else n_pass++;
  endtask

  task automatic test_timeout(input int ack_at, input string tag);
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    model(1'b0, ack_at, 32'h0BAD_0BAD, e_stb, e_err, e_dat);
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, ack_at, 32'h0BAD_0BAD, 3, o);
    n_chk++;
    if ({o.stb, o.attr_ok, o.v_at_end} !== {e_stb, 1'b1, 1'b1})
      $display("FAIL %s_stb got stb=%0d ok=%b rv=%b want stb=%0d ok=1 rv=1", tag, o.stb, o.attr_ok, o.v_at_end, e_stb);
    else n_pass++;
    n_chk++;
    if ({o.rerr, o.rdat, o.txn, o.errc} !== {e_err, e_dat, CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL %s_result got err=%b dat=%h txn=%0d errc=%0d want err=%b dat=%h txn=%0d errc=%0d",
               tag, o.rerr, o.rdat, o.txn, o.errc, e_err, e_dat, m_txn, m_err);
    else n_pass++;
    n_chk++;
    if ({o.hold_ok, o.post_busy, txn_count, err_count} !== {1'b1, 1'b0, CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL %s_stray_ack got hold_ok=%b busy=%b txn=%0d errc=%0d want 1 0 %0d %0d",
               tag, o.hold_ok, o.post_busy, txn_count, err_count, m_txn, m_err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    model(1'b0, 2, 32'hA5A5_0001, e_stb, e_err, e_dat);
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hC, 2, 32'hA5A5_0001, 5, o);
    n_chk++;
    if ({o.rdat, o.rerr, o.txn} !== {e_dat, e_err, CNT_W'(m_txn)})
      $display("FAIL bp_result got dat=%h err=%b txn=%0d want dat=%h err=%b txn=%0d",
               o.rdat, o.rerr, o.txn, e_dat, e_err, m_txn);
    else n_pass++;
    n_chk++;
    if (o.hold_ok !== 1'b1) $display("FAIL bp_hold_stable got %b want 1", o.hold_ok);
    else n_pass++;
    n_chk++;
    if ({o.post_busy, o.post_ready, o.post_valid} !== 3'b010)
      $display("FAIL bp_no_accept got busy=%b ready=%b rv=%b want 0 1 0", o.post_busy, o.post_ready, o.post_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat; int prev;
    logic we; logic [31:0] adr, dat, rd;
    prev = -1;
    for (int i = 0; i < 10; i++) begin
      we = 1'($urandom); adr = $urandom; dat = $urandom; rd = $urandom;
      model(we, 1, rd, e_stb, e_err, e_dat);
      run_txn(we, adr, dat, 4'($urandom), 1, rd, 0, o);
      if (prev >= 0) begin
        n_chk++;
        if (o.acc_cyc - prev !== 3)
          $display("FAIL b2b_interval[%0d] got %0d want 3", i, o.acc_cyc - prev);
        else n_pass++;
      end
      prev = o.acc_cyc;
      n_chk++;
      if ({o.stb, o.rerr, o.rdat, o.txn, o.we, o.adr, o.dat} !==
          {e_stb, e_err, e_dat, CNT_W'(m_txn), we, adr, dat})
        $display("FAIL b2b_result[%0d] got stb=%0d err=%b dat=%h txn=%0d adr=%h want stb=%0d err=%b dat=%h txn=%0d adr=%h",
                 i, o.stb, o.rerr, o.rdat, o.txn, o.adr, e_stb, e_err, e_dat, m_txn, adr);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({wbm_cyc_o, wbm_stb_o, busy} !== 3'b111)
      $display("FAIL rst_pre_bus got cyc=%b stb=%b busy=%b want 1 1 1", wbm_cyc_o, wbm_stb_o, busy);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_txn = 0; m_err = 0;
    n_chk++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, txn_count, err_count, cmd_ready} !== {6'b0, 2*CNT_W'(0), 1'b1})
      $display("FAIL rst_mid_bus got cyc=%b stb=%b rv=%b busy=%b txn=%0d errc=%0d ready=%b want 0 0 0 0 0 0 1",
               wbm_cyc_o, wbm_stb_o, rsp_valid, busy, txn_count, err_count, cmd_ready);
    else n_pass++;
    model(1'b0, 3, 32'h7777_8888, e_stb, e_err, e_dat);
    run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 3, 32'h7777_8888, 0, o);
    n_chk++;
    if ({o.stb, o.rerr, o.rdat, o.txn, o.errc} !== {e_stb, e_err, e_dat, CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL rst_after_txn got stb=%0d err=%b dat=%h txn=%0d errc=%0d want stb=%0d err=%b dat=%h txn=%0d errc=%0d",
               o.stb, o.rerr, o.rdat, o.txn, o.errc, e_stb, e_err, e_dat, m_txn, m_err);
    else n_pass++;
  endtask

  task automatic test_random(input int n);
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    logic we; logic [31:0] adr, dat, rd; int ack_at;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom); adr = $urandom; dat = $urandom; rd = $urandom;
      ack_at = $urandom_range(0, TIMEOUT + 2);
      model(we, ack_at, rd, e_stb, e_err, e_dat);
      run_txn(we, adr, dat, 4'($urandom), ack_at, rd, $urandom_range(0, 3), o);
      n_chk++;
      if ({o.stb, o.rerr, o.rdat, o.txn, o.errc, o.attr_ok, o.hold_ok, o.post_ready} !==
          {e_stb, e_err, e_dat, CNT_W'(m_txn), CNT_W'(m_err), 3'b111})
        $display("FAIL rand[%0d] ack_at=%0d got stb=%0d err=%b dat=%h txn=%0d errc=%0d flags=%b%b%b want stb=%0d err=%b dat=%h txn=%0d errc=%0d flags=111",
                 i, ack_at, o.stb, o.rerr, o.rdat, o.txn, o.errc, o.attr_ok, o.hold_ok, o.post_ready,
                 e_stb, e_err, e_dat, m_txn, m_err);
      else n_pass++;
    end
  endtask

  task automatic test_err_saturate();
    obs_t o; int e_stb; logic e_err; logic [31:0] e_dat;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      model(1'b1, 0, 32'h0, e_stb, e_err, e_dat);
      run_txn(1'b1, $urandom, $urandom, 4'hF, 0, 32'h0, 0, o);
    end
    n_chk++;
    if ({txn_count, err_count} !== {CNT_W'(m_txn), CNT_W'(m_err)})
      $display("FAIL sat_counters got txn=%0d errc=%0d want txn=%0d errc=%0d", txn_count, err_count, m_txn, m_err);
    else n_pass++;
    n_chk++;
    if (err_count !== '1) $display("FAIL sat_err_allones got %0d want %0d", err_count, (1 << CNT_W) - 1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_timeout(0, "timeout");
    test_timeout(TIMEOUT, "ack_at_limit");
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random(40);
    test_err_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
